// File: rtl/irq_controller.sv
// Interrupt source controller: synchronises external request lines, latches pending
// events and drives the CPU irq line with fixed-priority (index 0 highest) selection.
module irq_controller #(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] src_i,
    input  logic [N_SRC-1:0] ie_i,
    input  logic             ack_i,
    output logic             irq_o,
    output logic [N_SRC-1:0] cause_o,
    output logic [N_SRC-1:0] pending_o,
    output logic [N_SRC-1:0] overrun_o,
    output logic             spurious_o
);

    localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic logic [N_SRC-1:0] lowest_onehot(input logic [N_SRC-1:0] v);
        return v & (~v + N_SRC'(1));
    endfunction

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] overrun_q, overrun_d;
    logic [N_SRC-1:0] cause_q;
    logic [CW-1:0]    hold_cnt_q;
    logic             irq_q;
    logic             spurious_q;
    state_e           state_q;

    logic [N_SRC-1:0] synced_s, rise_s, req_s, clr_s;
    logic             take_s;

    // Event detection, priority selection and next pending/overrun vectors.
    always_comb begin
        synced_s = sync_q[SYNC_STAGES-1];
        if (EDGE_MODE) begin
            rise_s = synced_s & ~prev_q;
        end else begin
            rise_s = synced_s;
        end
        req_s  = pending_q & ie_i;
        take_s = (state_q == ST_ASSERT) && ack_i;
        if (take_s) begin
            clr_s = lowest_onehot(req_s);
        end else begin
            clr_s = '0;
        end
        // A fresh event on the same edge as its clear keeps the bit set, without overrun.
        pending_d = (pending_q & ~clr_s) | rise_s;
        if (EDGE_MODE) begin
            overrun_d = (overrun_q & ~clr_s) | (rise_s & pending_q & ~clr_s);
        end else begin
            overrun_d = '0;
        end
    end

    // Synchroniser chain, previous-sample flop and pending/overrun registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], src_i};
            prev_q    <= sync_q[SYNC_STAGES-1];
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Request/acknowledge FSM with registered irq, cause and spurious outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            cause_q    <= '0;
            hold_cnt_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= ack_i && (state_q != ST_ASSERT);
            case (state_q)
                ST_IDLE: begin
                    if (req_s != '0) begin
                        state_q <= ST_ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (ack_i) begin
                        cause_q    <= clr_s;
                        irq_q      <= 1'b0;
                        hold_cnt_q <= HOLD_LOAD;
                        state_q    <= ST_HOLD;
                    end else if (req_s == '0) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == CNT_ONE) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o      = irq_q;
    assign cause_o    = cause_q;
    assign pending_o  = pending_q;
    assign overrun_o  = overrun_q;
    assign spurious_o = spurious_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller: a cycle-level reference model pushes
// expected outputs per clock; an independent monitor pops and compares on the falling edge.
module tb_irq_controller;

    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam bit EDGE  = 1'b1;
    localparam int HOLD  = 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] src   = '0;
    logic [N-1:0] ie    = '0;
    logic         ack   = 1'b0;
    logic         irq;
    logic [N-1:0] cause, pending, overrun;
    logic         spurious;

    irq_controller #(.N_SRC(N), .SYNC_STAGES(SYNC), .EDGE_MODE(EDGE), .HOLD_CYCLES(HOLD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .src_i(src), .ie_i(ie), .ack_i(ack),
        .irq_o(irq), .cause_o(cause), .pending_o(pending), .overrun_o(overrun),
        .spurious_o(spurious)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         irq;
        logic [N-1:0] cause;
        logic [N-1:0] pend;
        logic [N-1:0] ovr;
        logic         spur;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 = idle, 1 = requesting, 2 = holding off after ack.
    int           m_st;
    int           m_hold;
    bit           m_irq, m_spur;
    bit [N-1:0]   m_cause, m_pend, m_ovr;
    bit [N-1:0]   hist[$];

    task automatic model_reset();
        m_st = 0; m_hold = 0; m_irq = 0; m_spur = 0;
        m_cause = '0; m_pend = '0; m_ovr = '0;
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back('0);
    endtask

    task automatic model_step();
        bit [N-1:0] sync_v, prev_v, ev, req, np, no;
        int sel;
        sync_v = hist[SYNC-1];
        prev_v = hist[SYNC];
        sel = -1;
        for (int i = N - 1; i >= 0; i--) begin
            ev[i]  = EDGE ? (sync_v[i] && !prev_v[i]) : sync_v[i];
            req[i] = m_pend[i] && ie[i];
            if (req[i]) sel = i;
        end
        m_spur = ack && (m_st != 1);
        np = m_pend;
        no = m_ovr;
        case (m_st)
            0: if (req != 0) begin m_st = 1; m_irq = 1; end
            1: begin
                if (ack) begin
                    if (sel >= 0) begin
                        np[sel] = 0; no[sel] = 0; m_cause = N'(1 << sel);
                    end else begin
                        m_cause = '0;
                    end
                    m_irq = 0; m_hold = HOLD; m_st = 2;
                end else if (req == 0) begin
                    m_irq = 0; m_st = 0;
                end
            end
            default: begin
                if (m_hold == 1) m_st = 0;
                else m_hold = m_hold - 1;
            end
        endcase
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (EDGE && m_pend[i] && np[i]) no[i] = 1;
                np[i] = 1;
            end
        end
        m_pend = np;
        m_ovr  = no;
        hist.push_front(src);
        void'(hist.pop_back());
    endtask

    task automatic cycle(input logic [N-1:0] s, input logic [N-1:0] e, input logic a,
                         input logic r);
        exp_t x;
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        src = s; ie = e; ack = a; rst_n = r;
        if (!r) model_reset();
        x.irq = m_irq; x.cause = m_cause; x.pend = m_pend; x.ovr = m_ovr; x.spur = m_spur;
        sbq.push_back(x);
    endtask

    task automatic run_random(input int n, input logic [N-1:0] smask, input int ie_mode,
                              input int rst_prob);
        logic [N-1:0] s, e;
        logic a, r;
        s = src; e = ie;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < N; b++)
                if (smask[b] && $urandom_range(0, 4) == 0) s[b] = ~s[b];
            s = s & smask;
            case (ie_mode)
                0: e = 4'b0001;
                1: e = 4'b1111;
                default: if ($urandom_range(0, 9) == 0) e = 4'($urandom_range(0, 15));
            endcase
            a = 1'b0;
            if (!ack) begin
                if (m_irq && $urandom_range(0, 3) == 0) a = 1'b1;
                else if ($urandom_range(0, 29) == 0) a = 1'b1;
            end
            r = !(rst_prob > 0 && $urandom_range(0, rst_prob - 1) == 0);
            cycle(s, e, a, r);
        end
    endtask

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exv);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("irq",      {3'b000, irq},      {3'b000, x.irq});
                chk("cause",    cause,              x.cause);
                chk("pending",  pending,            x.pend);
                chk("overrun",  overrun,            x.ovr);
                chk("spurious", {3'b000, spurious}, {3'b000, x.spur});
            end
        end
    end

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(4'b0000, 4'b0001, 1'b0, 1'b1);
        // Single narrow pulse on source 0, then a prompt ack.
        cycle(4'b0001, 4'b0001, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cycle(4'b0000, 4'b0001, 1'b0, 1'b1);
        cycle(4'b0000, 4'b0001, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(4'b0000, 4'b0001, 1'b0, 1'b1);
        // Spurious ack while idle.
        cycle(4'b0000, 4'b0001, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(4'b0000, 4'b0001, 1'b0, 1'b1);
        run_random(300, 4'b0001, 0, 0);
        run_random(800, 4'b1111, 1, 0);
        run_random(800, 4'b1111, 2, 0);
        // Reset asserted while an interrupt is outstanding.
        for (int k = 0; k < 3; k++) cycle(4'b0000, 4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < 20 && !m_irq; k++) cycle(4'b0011, 4'b1111, 1'b0, 1'b1);
        checks++;
        if (!m_irq) begin
            errors++;
            $display("FAIL wait_irq: irq expectation never reached within 20 cycles");
        end
        cycle(4'b0000, 4'b1111, 1'b0, 1'b0);
        cycle(4'b0000, 4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cycle(4'b0000, 4'b1111, 1'b0, 1'b1);
        run_random(500, 4'b1111, 2, 150);
        run_random(200, 4'b1111, 2, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
